// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Pipeline hazard controller built around a DEPTH-entry scoreboard.
//   The scoreboard tracks every instruction after decode. Entry 0 is E,
//   entries 1..LOAD_LAT are M1..ML, and entry DEPTH-1 is W.
//   From the scoreboard the block derives:
//   - the load-use stall,
//   - branch flushes,
//   - a data-memory busy freeze,
//   - the E-stage forwarding selects,
//   - saturating stall and flush counters.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   valid_D             D holds a real instruction
//   rs_D, rt_D          source register ids in D
//   use_rs_D, use_rt_D  source actually read by the D instruction
//   reg_write_D         D instruction writes the register file
//   mem_to_reg_D        D instruction is a load
//   dst_D               destination id of the D instruction
//   rs_E, rt_E          source ids held in the D/E register
//   br_taken_E          branch/jump resolved taken in E
//   dmem_busy           data memory not ready
//   pc_enab, enab_FD    PC and F/D register enables
//   flush_FD, flush_DE  clear F/D and D/E
//   pipe_enab           enable for D/E and all later pipeline registers
//   fwd_a_E, fwd_b_E    operand select: 0 = D/E value, k = result of entry k
//   stall_cnt           saturating count of load-use stall cycles
//   flush_cnt           saturating count of taken-branch flushes
module hazard_scoreboard #(
  parameter int RID_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int DEPTH    = LOAD_LAT + 2,
  parameter int FSEL_W   = $clog2(DEPTH),
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_D,
  input  logic [RID_W-1:0]  rs_D,
  input  logic [RID_W-1:0]  rt_D,
  input  logic              use_rs_D,
  input  logic              use_rt_D,
  input  logic              reg_write_D,
  input  logic              mem_to_reg_D,
  input  logic [RID_W-1:0]  dst_D,
  input  logic [RID_W-1:0]  rs_E,
  input  logic [RID_W-1:0]  rt_E,
  input  logic              br_taken_E,
  input  logic              dmem_busy,
  output logic              pc_enab,
  output logic              enab_FD,
  output logic              flush_FD,
  output logic              flush_DE,
  output logic              pipe_enab,
  output logic [FSEL_W-1:0] fwd_a_E,
  output logic [FSEL_W-1:0] fwd_b_E,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Scoreboard state, one bit/field per stage after decode
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] reg_write_r;
  logic [DEPTH-1:0] mem_to_reg_r;
  logic [RID_W-1:0] dst_r [DEPTH];

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic              stall_rs_s;
  logic              stall_rt_s;
  logic              stall_s;
  logic [FSEL_W-1:0] fwd_a_s;
  logic [FSEL_W-1:0] fwd_b_s;
  logic              pc_enab_s;
  logic              enab_fd_s;
  logic              flush_fd_s;
  logic              flush_de_s;
  logic              pipe_enab_s;
  logic [FSEL_W-1:0] fwd_a_out_s;
  logic [FSEL_W-1:0] fwd_b_out_s;
  logic              stall_inc_s;
  logic              flush_inc_s;

  // An entry produces register r; register 0 is hard-wired and never matches.
  function automatic logic match_f(input logic v, input logic rw,
                                   input logic [RID_W-1:0] dst,
                                   input logic [RID_W-1:0] r);
    return v & rw & (dst == r) & (r != {RID_W{1'b0}});
  endfunction

  // First entry index at which the result can be forwarded.
  function automatic int avail_f(input logic mtr);
    return mtr ? (LOAD_LAT + 1) : 1;
  endfunction

  // Load-use detection: scan old to young so the youngest match wins.
  always_comb begin
    stall_rs_s = 1'b0;
    stall_rt_s = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_f(valid_r[k], reg_write_r[k], dst_r[k], rs_D)) begin
        stall_rs_s = (k + 1 < avail_f(mem_to_reg_r[k]));
      end else begin
        stall_rs_s = stall_rs_s;
      end
      if (match_f(valid_r[k], reg_write_r[k], dst_r[k], rt_D)) begin
        stall_rt_s = (k + 1 < avail_f(mem_to_reg_r[k]));
      end else begin
        stall_rt_s = stall_rt_s;
      end
    end
    stall_s = valid_D & ((use_rs_D & stall_rs_s) | (use_rt_D & stall_rt_s));
  end

  // Forward selection: youngest producer in entries 1..DEPTH-1; entry 0 is E itself.
  always_comb begin
    fwd_a_s = {FSEL_W{1'b0}};
    fwd_b_s = {FSEL_W{1'b0}};
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (match_f(valid_r[k], reg_write_r[k], dst_r[k], rs_E)) begin
        fwd_a_s = (k < avail_f(mem_to_reg_r[k])) ? {FSEL_W{1'b0}} : FSEL_W'(k);
      end else begin
        fwd_a_s = fwd_a_s;
      end
      if (match_f(valid_r[k], reg_write_r[k], dst_r[k], rt_E)) begin
        fwd_b_s = (k < avail_f(mem_to_reg_r[k])) ? {FSEL_W{1'b0}} : FSEL_W'(k);
      end else begin
        fwd_b_s = fwd_b_s;
      end
    end
  end

  // Control priority: reset, memory freeze, taken branch, load-use stall, normal flow.
  always_comb begin
    pc_enab_s   = 1'b1;
    enab_fd_s   = 1'b1;
    flush_fd_s  = 1'b0;
    flush_de_s  = 1'b0;
    pipe_enab_s = 1'b1;
    fwd_a_out_s = fwd_a_s;
    fwd_b_out_s = fwd_b_s;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    if (!reset) begin
      pc_enab_s   = 1'b0;
      enab_fd_s   = 1'b0;
      flush_fd_s  = 1'b1;
      flush_de_s  = 1'b1;
      pipe_enab_s = 1'b0;
      fwd_a_out_s = {FSEL_W{1'b0}};
      fwd_b_out_s = {FSEL_W{1'b0}};
    end else if (dmem_busy) begin
      // Whole pipeline frozen; a taken branch stays in D/E until the freeze lifts.
      pc_enab_s   = 1'b0;
      enab_fd_s   = 1'b0;
      pipe_enab_s = 1'b0;
    end else if (br_taken_E) begin
      // The D instruction is squashed, so any pending stall is irrelevant.
      flush_fd_s  = 1'b1;
      flush_de_s  = 1'b1;
      flush_inc_s = 1'b1;
    end else if (stall_s) begin
      pc_enab_s   = 1'b0;
      enab_fd_s   = 1'b0;
      flush_de_s  = 1'b1;
      stall_inc_s = 1'b1;
    end else begin
      pc_enab_s   = 1'b1;
      pipe_enab_s = 1'b1;
    end
  end

  // Scoreboard shift: D (or a bubble) enters entry 0, entry DEPTH-1 retires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r      <= {DEPTH{1'b0}};
      reg_write_r  <= {DEPTH{1'b0}};
      mem_to_reg_r <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        dst_r[k] <= {RID_W{1'b0}};
      end
    end else if (pipe_enab_s) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_r[k]      <= valid_r[k-1];
        reg_write_r[k]  <= reg_write_r[k-1];
        mem_to_reg_r[k] <= mem_to_reg_r[k-1];
        dst_r[k]        <= dst_r[k-1];
      end
      valid_r[0]      <= valid_D & ~flush_de_s;
      reg_write_r[0]  <= reg_write_D;
      mem_to_reg_r[0] <= mem_to_reg_D;
      dst_r[0]        <= dst_D;
    end
  end

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pc_enab   = pc_enab_s;
  assign enab_FD   = enab_fd_s;
  assign flush_FD  = flush_fd_s;
  assign flush_DE  = flush_de_s;
  assign pipe_enab = pipe_enab_s;
  assign fwd_a_E   = fwd_a_out_s;
  assign fwd_b_E   = fwd_b_out_s;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: one instance with LOAD_LAT=1 and
// one with LOAD_LAT=2 share the same stimulus. Directed test-plan steps are
// followed by a random phase. Every cycle is compared against a queue-based
// model of the in-flight instructions.
module tb_hazard_scoreboard;

  typedef struct packed {
    bit       v;
    bit       rw;
    bit       mtr;
    bit [4:0] dst;
  } entry_t;

  typedef struct packed {
    bit       pc;
    bit       fd;
    bit       ffd;
    bit       fde;
    bit       pe;
    bit       inc_s;
    bit       inc_f;
    bit [1:0] fa;
    bit [1:0] fb;
  } ctl_t;

  logic       clk;
  logic       reset;
  logic       valid_D, use_rs_D, use_rt_D, reg_write_D, mem_to_reg_D;
  logic [4:0] rs_D, rt_D, dst_D, rs_E, rt_E;
  logic       br_taken_E, dmem_busy;

  logic        pc_1, fd_1, ffd_1, fde_1, pe_1;
  logic [1:0]  fa_1, fb_1;
  logic [31:0] sc_1, fc_1;
  logic        pc_2, fd_2, ffd_2, fde_2, pe_2;
  logic [1:0]  fa_2, fb_2;
  logic [31:0] sc_2, fc_2;

  int errors = 0;
  int checks = 0;

  entry_t    q1[$];
  entry_t    q2[$];
  bit [31:0] ms1, mf1, ms2, mf2;

  hazard_scoreboard #(.LOAD_LAT(1)) u_ll1 (
    .clk(clk), .reset(reset), .valid_D(valid_D), .rs_D(rs_D), .rt_D(rt_D),
    .use_rs_D(use_rs_D), .use_rt_D(use_rt_D), .reg_write_D(reg_write_D),
    .mem_to_reg_D(mem_to_reg_D), .dst_D(dst_D), .rs_E(rs_E), .rt_E(rt_E),
    .br_taken_E(br_taken_E), .dmem_busy(dmem_busy),
    .pc_enab(pc_1), .enab_FD(fd_1), .flush_FD(ffd_1), .flush_DE(fde_1),
    .pipe_enab(pe_1), .fwd_a_E(fa_1), .fwd_b_E(fb_1),
    .stall_cnt(sc_1), .flush_cnt(fc_1));

  hazard_scoreboard #(.LOAD_LAT(2)) u_ll2 (
    .clk(clk), .reset(reset), .valid_D(valid_D), .rs_D(rs_D), .rt_D(rt_D),
    .use_rs_D(use_rs_D), .use_rt_D(use_rt_D), .reg_write_D(reg_write_D),
    .mem_to_reg_D(mem_to_reg_D), .dst_D(dst_D), .rs_E(rs_E), .rt_E(rt_E),
    .br_taken_E(br_taken_E), .dmem_busy(dmem_busy),
    .pc_enab(pc_2), .enab_FD(fd_2), .flush_FD(ffd_2), .flush_DE(fde_2),
    .pipe_enab(pe_2), .fwd_a_E(fa_2), .fwd_b_E(fb_2),
    .stall_cnt(sc_2), .flush_cnt(fc_2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the youngest in-flight instruction at or after 'from' that writes r.
  function automatic int young(input entry_t q[$], input int from, input bit [4:0] r);
    for (int k = from; k < q.size(); k++) begin
      if (q[k].v && q[k].rw && q[k].dst == r && r != 5'd0) return k;
    end
    return -1;
  endfunction

  // Number of stages after E at which an instruction's result exists.
  function automatic int ready_at(input entry_t e, input int ll);
    return e.mtr ? ll + 1 : 1;
  endfunction

  function automatic bit src_stall(input entry_t q[$], input int ll, input bit [4:0] r);
    int i;
    i = young(q, 0, r);
    if (i < 0) return 1'b0;
    return (i + 1 < ready_at(q[i], ll));
  endfunction

  function automatic bit [1:0] fwd_of(input entry_t q[$], input int ll, input bit [4:0] r);
    int i;
    i = young(q, 1, r);
    if (i < 0) return 2'd0;
    if (i < ready_at(q[i], ll)) return 2'd0;
    return 2'(i);
  endfunction

  function automatic ctl_t model_ctl(input entry_t q[$], input int ll);
    ctl_t c;
    bit   st;
    st = valid_D && ((use_rs_D && src_stall(q, ll, rs_D)) ||
                     (use_rt_D && src_stall(q, ll, rt_D)));
    c = '0;
    if (!reset) begin
      c.ffd = 1'b1;
      c.fde = 1'b1;
    end else begin
      c.fa = fwd_of(q, ll, rs_E);
      c.fb = fwd_of(q, ll, rt_E);
      if (dmem_busy) begin
        c.pc = 1'b0;
      end else if (br_taken_E) begin
        c.pc = 1'b1; c.fd = 1'b1; c.ffd = 1'b1; c.fde = 1'b1; c.pe = 1'b1;
        c.inc_f = 1'b1;
      end else if (st) begin
        c.fde = 1'b1; c.pe = 1'b1; c.inc_s = 1'b1;
      end else begin
        c.pc = 1'b1; c.fd = 1'b1; c.pe = 1'b1;
      end
    end
    return c;
  endfunction

  function automatic bit [31:0] sat(input bit [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cfg(input string n, input ctl_t c, input bit [31:0] es,
                           input bit [31:0] ef, input logic pc, input logic fd,
                           input logic ffd, input logic fde, input logic pe,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] sc, input logic [31:0] fc);
    chk({n, ".pc_enab"},   {31'd0, pc},  {31'd0, c.pc});
    chk({n, ".enab_FD"},   {31'd0, fd},  {31'd0, c.fd});
    chk({n, ".flush_FD"},  {31'd0, ffd}, {31'd0, c.ffd});
    chk({n, ".flush_DE"},  {31'd0, fde}, {31'd0, c.fde});
    chk({n, ".pipe_enab"}, {31'd0, pe},  {31'd0, c.pe});
    chk({n, ".fwd_a_E"},   {30'd0, fa},  {30'd0, c.fa});
    chk({n, ".fwd_b_E"},   {30'd0, fb},  {30'd0, c.fb});
    chk({n, ".stall_cnt"}, sc, es);
    chk({n, ".flush_cnt"}, fc, ef);
  endtask

  // Move to the sampling point and compare both instances with the model.
  task automatic settle();
    @(negedge clk);
    check_cfg("ll1", model_ctl(q1, 1), ms1, mf1, pc_1, fd_1, ffd_1, fde_1, pe_1,
              fa_1, fb_1, sc_1, fc_1);
    check_cfg("ll2", model_ctl(q2, 2), ms2, mf2, pc_2, fd_2, ffd_2, fde_2, pe_2,
              fa_2, fb_2, sc_2, fc_2);
  endtask

  // Advance the model across the clock edge.
  task automatic tick();
    ctl_t   c1, c2;
    entry_t e, blank;
    blank = '0;
    c1 = model_ctl(q1, 1);
    c2 = model_ctl(q2, 2);
    e.v = valid_D; e.rw = reg_write_D; e.mtr = mem_to_reg_D; e.dst = dst_D;
    @(posedge clk);
    if (!reset) begin
      q1.delete(); q2.delete();
      repeat (3) q1.push_back(blank);
      repeat (4) q2.push_back(blank);
      ms1 = 32'd0; mf1 = 32'd0; ms2 = 32'd0; mf2 = 32'd0;
    end else begin
      if (c1.pe) begin
        q1.push_front(c1.fde ? blank : e);
        void'(q1.pop_back());
      end
      if (c2.pe) begin
        q2.push_front(c2.fde ? blank : e);
        void'(q2.pop_back());
      end
      if (c1.inc_f) mf1 = sat(mf1);
      if (c1.inc_s) ms1 = sat(ms1);
      if (c2.inc_f) mf2 = sat(mf2);
      if (c2.inc_s) ms2 = sat(ms2);
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic set_d(input bit v, input bit [4:0] rs, input bit urs, input bit [4:0] rt,
                       input bit urt, input bit rw, input bit mtr, input bit [4:0] dst);
    valid_D = v; rs_D = rs; use_rs_D = urs; rt_D = rt; use_rt_D = urt;
    reg_write_D = rw; mem_to_reg_D = mtr; dst_D = dst;
  endtask

  task automatic set_e(input bit [4:0] rse, input bit [4:0] rte, input bit br, input bit busy);
    rs_E = rse; rt_E = rte; br_taken_E = br; dmem_busy = busy;
  endtask

  task automatic nops(input int n);
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_e(5'd0, 5'd0, 1'b0, 1'b0);
    repeat (n) cyc();
  endtask

  initial begin
    entry_t blank;
    blank = '0;
    repeat (3) q1.push_back(blank);
    repeat (4) q2.push_back(blank);
    ms1 = 32'd0; mf1 = 32'd0; ms2 = 32'd0; mf2 = 32'd0;
    reset = 1'b0;
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_e(5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset active
    settle();
    chk("rst_pc_enab", {31'd0, pc_1}, 32'd0);
    chk("rst_flush_FD", {31'd0, ffd_1}, 32'd1);
    tick();
    reset = 1'b1;
    settle();
    chk("post_rst_pc_enab", {31'd0, pc_1}, 32'd1);
    chk("post_rst_stall_cnt", sc_2, 32'd0);
    tick();

    // ALU result forwarded from M1 then W
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3);
    cyc();
    set_d(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7);
    set_e(5'd1, 5'd2, 1'b0, 1'b0);
    settle(); chk("alu_no_stall", {31'd0, pc_1}, 32'd1); tick();
    set_d(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8);
    set_e(5'd3, 5'd0, 1'b0, 1'b0);
    settle(); chk("alu_fwd_m1", {30'd0, fa_1}, 32'd1); tick();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    settle(); chk("alu_fwd_w", {30'd0, fa_1}, 32'd2); tick();

    // LOAD_LAT=1 load-use: one stall cycle, then forward from W
    nops(3);
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
    cyc();
    set_d(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd9);
    settle();
    chk("lu1_pc_enab", {31'd0, pc_1}, 32'd0);
    chk("lu1_flush_DE", {31'd0, fde_1}, 32'd1);
    tick();
    settle(); chk("lu1_release", {31'd0, pc_1}, 32'd1); tick();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_e(5'd0, 5'd5, 1'b0, 1'b0);
    settle();
    chk("lu1_fwd_b", {30'd0, fb_1}, 32'd2);
    chk("lu1_stall_cnt", sc_1, 32'd1);
    tick();

    // LOAD_LAT=2 load-use: two stall cycles, then forward from W
    nops(4);
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
    cyc();
    set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9);
    settle(); chk("lu2_stall_1", {31'd0, pc_2}, 32'd0); tick();
    settle(); chk("lu2_stall_2", {31'd0, pc_2}, 32'd0); tick();
    settle(); chk("lu2_release", {31'd0, pc_2}, 32'd1); tick();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_e(5'd5, 5'd0, 1'b0, 1'b0);
    settle(); chk("lu2_fwd_a", {30'd0, fa_2}, 32'd3); tick();

    // LOAD_LAT=2 with one independent instruction between: one stall cycle
    nops(4);
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6);
    cyc();
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd9);
    cyc();
    set_d(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd10);
    settle(); chk("gap_stall", {31'd0, pc_2}, 32'd0); tick();
    settle(); chk("gap_release", {31'd0, pc_2}, 32'd1); tick();

    // Load-use coinciding with a taken branch
    nops(4);
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
    cyc();
    set_d(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd9);
    set_e(5'd0, 5'd0, 1'b1, 1'b0);
    settle();
    chk("br_pc_enab", {31'd0, pc_1}, 32'd1);
    chk("br_flush_FD", {31'd0, ffd_1}, 32'd1);
    chk("br_flush_DE", {31'd0, fde_1}, 32'd1);
    tick();
    nops(1);

    // Data-memory busy for three cycles with a live forward
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd4);
    cyc();
    set_d(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd10);
    cyc();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_e(5'd4, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("busy_pipe_enab", {31'd0, pe_1}, 32'd0);
      chk("busy_fwd_a", {30'd0, fa_1}, 32'd1);
      tick();
    end
    set_e(5'd4, 5'd0, 1'b0, 1'b0);
    settle();
    chk("busy_resume_pe", {31'd0, pe_1}, 32'd1);
    chk("busy_resume_fwd", {30'd0, fa_1}, 32'd1);
    tick();

    // r0 never stalls; duplicate destination picks the youngest
    nops(4);
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0);
    cyc();
    set_d(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9);
    settle();
    chk("r0_no_stall_ll1", {31'd0, pc_1}, 32'd1);
    chk("r0_no_stall_ll2", {31'd0, pc_2}, 32'd1);
    tick();
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd8);
    cyc();
    set_d(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd8);
    cyc();
    set_d(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd11);
    cyc();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_e(5'd8, 5'd8, 1'b0, 1'b0);
    settle();
    chk("dup_youngest_ll1", {30'd0, fa_1}, 32'd1);
    chk("dup_youngest_ll2", {30'd0, fb_2}, 32'd1);
    tick();

    // Reset asserted during a load-use stall
    nops(3);
    set_d(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5);
    cyc();
    set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9);
    reset = 1'b0;
    settle();
    chk("rst_stall_pe", {31'd0, pe_1}, 32'd0);
    chk("rst_stall_flush_FD", {31'd0, ffd_1}, 32'd1);
    tick();
    settle();
    chk("rst_stall_cnt", sc_1, 32'd0);
    chk("rst_flush_cnt", fc_1, 32'd0);
    tick();
    reset = 1'b1;
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    settle(); chk("rst_release_pc", {31'd0, pc_1}, 32'd1); tick();

    // Random phase against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      set_d(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)));
      set_e(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
